psx_ddr_burst_bridge: RTL and testbench

Parametrised bridge between the GPU's block-oriented memory client port and an Avalon-MM DDR master port. It accepts one client read or write command of 4 bytes, 8 bytes or a full client line, and splits it into MEM_W-wide beats. The beats are issued either as one true Avalon burst or as consecutive single-beat requests. Read data is reassembled into a full client line. It sits between the GPU memory arbiter and the DDR controller.

---
 rtl/psx_ddr_pkg.sv | 26 ++
 rtl/psx_ddr_lane_sel.sv | 67 ++++++
 rtl/psx_ddr_burst_bridge.sv | 191 +++++++++++++++++++
 tb/tb_psx_ddr_burst_bridge.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/psx_ddr_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : psx_ddr_pkg
//  Description : Shared types for the GPU-client to Avalon-MM DDR bridge.
//                These are the command size encoding and the bridge FSM states.
//  Revision    : 1.0 - initial release
// ============================================================================
package psx_ddr_pkg;

    // Client command size as presented on i_commandSize (3 decodes as 8 bytes)
    typedef enum logic [1:0] {
        CMD_8BYTE  = 2'd0,
        CMD_32BYTE = 2'd1,
        CMD_4BYTE  = 2'd2
    } cmd_size_t;

    // Bridge control states
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_REQ  = 2'd1,
        RD_WAIT = 2'd2,
        WR_BEAT = 2'd3
    } bridge_state_t;

endpackage
`default_nettype wire

// File: rtl/psx_ddr_lane_sel.sv
`default_nettype none
// ============================================================================
//  Module      : psx_ddr_lane_sel
//  Description : Combinational write-beat builder. It picks the MEM_W slice of
//                the client line for the current beat and expands the
//                halfword mask into Avalon byteenables.
//  Revision    : 1.0 - initial release
// ============================================================================
module psx_ddr_lane_sel #(
    parameter  int CLIENT_W = 256,
    parameter  int MEM_W    = 64,
    localparam int BEATS    = CLIENT_W / MEM_W,
    localparam int BEAT_W   = $clog2(BEATS),
    localparam int WPB      = MEM_W / 32,
    localparam int WSEL_W   = $clog2(WPB)
) (
    input  logic [CLIENT_W-1:0]    i_lineData,
    input  logic [CLIENT_W/16-1:0] i_lineMask,
    input  logic [BEAT_W-1:0]      i_lane,
    input  logic [WSEL_W-1:0]      i_word,
    input  logic                   i_isLine,
    input  logic                   i_is4B,
    output logic [MEM_W-1:0]       o_beatData,
    output logic [MEM_W/8-1:0]     o_beatBe
);

    localparam int HW = MEM_W / 16;

    logic [MEM_W-1:0] w_laneData;
    logic [HW-1:0]    w_laneMask;

    // Select the data and mask slice belonging to the current beat lane
    always_comb begin
        w_laneData = '0;
        w_laneMask = '0;
        for (int k = 0; k < BEATS; k++) begin
            if (i_lane == BEAT_W'(k)) begin
                w_laneData = i_lineData[k*MEM_W +: MEM_W];
                w_laneMask = i_lineMask[k*HW +: HW];
            end
        end
    end

    // A 4-byte write carries the low client word replicated into every lane
    always_comb begin
        o_beatData = i_is4B ? {WPB{i_lineData[31:0]}} : w_laneData;
    end

    // Byteenables: word-granular for 4B, halfword mask for full line, else all
    always_comb begin
        o_beatBe = '1;
        if (i_is4B) begin
            o_beatBe = '0;
            for (int w = 0; w < WPB; w++) begin
                if (i_word == WSEL_W'(w)) begin
                    o_beatBe[w*4 +: 4] = {{2{i_lineMask[1]}}, {2{i_lineMask[0]}}};
                end
            end
        end else if (i_isLine) begin
            for (int h = 0; h < HW; h++) begin
                o_beatBe[h*2 +: 2] = {2{w_laneMask[h]}};
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/psx_ddr_burst_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : psx_ddr_burst_bridge
//  Description : Splits one GPU client read/write command (4B, 8B, full line)
//                into MEM_W-wide Avalon-MM beats. The beats go out either as
//                one burst or as single-beat requests. Read beats are
//                reassembled into a client line.
//  Revision    : 1.0 - initial release
// ============================================================================
module psx_ddr_burst_bridge #(
    parameter  int CLIENT_W  = 256,
    parameter  int MEM_W     = 64,
    parameter  int BLK_ADR_W = 15,
    parameter  int USE_BURST = 1,
    localparam int BEATS     = CLIENT_W / MEM_W,
    localparam int BEAT_W    = $clog2(BEATS),
    localparam int SUB_W     = $clog2(CLIENT_W / 32),
    localparam int MEM_ADR_W = BLK_ADR_W + BEAT_W,
    localparam int BC_W      = $clog2(BEATS) + 1
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_command,
    input  logic                   i_writeElseRead,
    input  logic [1:0]             i_commandSize,
    input  logic [BLK_ADR_W-1:0]   i_targetAddr,
    input  logic [SUB_W-1:0]       i_subAddr,
    input  logic [CLIENT_W/16-1:0] i_writeMask,
    input  logic [CLIENT_W-1:0]    i_dataClient,
    output logic                   o_busyClient,
    output logic                   o_dataValidClient,
    output logic [CLIENT_W-1:0]    o_dataClient,
    output logic [MEM_ADR_W-1:0]   o_targetAddr,
    output logic [BC_W-1:0]        o_burstLength,
    input  logic                   i_busyMem,
    output logic                   o_readEnableMem,
    output logic                   o_writeEnableMem,
    output logic [MEM_W-1:0]       o_dataMem,
    output logic [MEM_W/8-1:0]     o_byteEnableMem,
    input  logic                   i_dataValidMem,
    input  logic [MEM_W-1:0]       i_dataMem
);

    import psx_ddr_pkg::*;

    // Word-within-beat select width; the remaining subaddress bits pick the beat
    localparam int WSEL_W = SUB_W - BEAT_W;

    bridge_state_t           r_state;
    logic [BLK_ADR_W-1:0]    r_blk;
    logic                    r_isLine;
    logic                    r_is4B;
    logic [BEAT_W-1:0]       r_startBeat;
    logic [WSEL_W-1:0]       r_word;
    logic [BEAT_W-1:0]       r_lastIdx;
    logic [BEAT_W-1:0]       r_emitCnt;
    logic [BEAT_W-1:0]       r_recvCnt;
    logic [CLIENT_W/16-1:0]  r_mask;
    logic [CLIENT_W-1:0]     r_wdata;
    logic [CLIENT_W-1:0]     r_line;
    logic                    r_valid;

    logic                    w_cmdIsLine;
    logic                    w_cmdIs4B;
    logic [BEAT_W-1:0]       w_beatIdx;
    logic                    w_lastEmit;
    logic                    w_rxBeat;
    logic                    w_lastRecv;
    logic                    w_rdDone;
    logic [MEM_W-1:0]        w_rxLane;
    logic [MEM_W-1:0]        w_beatData;
    logic [MEM_W/8-1:0]      w_beatBe;

    // Command decode, beat bookkeeping and Avalon-side request outputs
    always_comb begin
        w_cmdIsLine       = (i_commandSize == CMD_32BYTE);
        w_cmdIs4B         = (i_commandSize == CMD_4BYTE);
        // Burst mode keeps the start address for the whole burst
        w_beatIdx         = (USE_BURST != 0) ? r_startBeat : r_startBeat + r_emitCnt;
        w_lastEmit        = (r_emitCnt == r_lastIdx);
        w_rxBeat          = i_dataValidMem && ((r_state == RD_REQ) || (r_state == RD_WAIT));
        w_lastRecv        = (r_recvCnt == r_lastIdx);
        w_rdDone          = (r_state == RD_WAIT) && i_dataValidMem && w_lastRecv;
        // An odd 4-byte word is shifted down so the client always sees it at [31:0]
        w_rxLane          = r_is4B ? (i_dataMem >> {r_word, 5'd0}) : i_dataMem;
        o_busyClient      = (r_state != IDLE);
        o_readEnableMem   = (r_state == RD_REQ);
        o_writeEnableMem  = (r_state == WR_BEAT);
        o_targetAddr      = {r_blk, w_beatIdx};
        o_burstLength     = (USE_BURST != 0) ? BC_W'(r_lastIdx) + BC_W'(1) : BC_W'(1);
        o_dataMem         = w_beatData;
        o_byteEnableMem   = (r_state == WR_BEAT) ? w_beatBe : '1;
        o_dataValidClient = r_valid;
        o_dataClient      = r_line;
    end

    psx_ddr_lane_sel #(
        .CLIENT_W (CLIENT_W),
        .MEM_W    (MEM_W)
    ) u_laneSel (
        .i_lineData (r_wdata),
        .i_lineMask (r_mask),
        .i_lane     (r_emitCnt),
        .i_word     (r_word),
        .i_isLine   (r_isLine),
        .i_is4B     (r_is4B),
        .o_beatData (w_beatData),
        .o_beatBe   (w_beatBe)
    );

    // Control FSM: latch the command, issue requests/beats, count returned data
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_blk       <= '0;
            r_isLine    <= 1'b0;
            r_is4B      <= 1'b0;
            r_startBeat <= '0;
            r_word      <= '0;
            r_lastIdx   <= '0;
            r_emitCnt   <= '0;
            r_recvCnt   <= '0;
            r_mask      <= '0;
            r_wdata     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_command) begin
                        r_blk       <= i_targetAddr;
                        r_isLine    <= w_cmdIsLine;
                        r_is4B      <= w_cmdIs4B;
                        r_startBeat <= w_cmdIsLine ? '0 : i_subAddr[SUB_W-1:WSEL_W];
                        r_word      <= i_subAddr[WSEL_W-1:0];
                        r_lastIdx   <= w_cmdIsLine ? BEAT_W'(BEATS - 1) : '0;
                        r_mask      <= i_writeMask;
                        r_wdata     <= i_dataClient;
                        r_emitCnt   <= '0;
                        r_recvCnt   <= '0;
                        r_state     <= i_writeElseRead ? WR_BEAT : RD_REQ;
                    end
                end
                RD_REQ: begin
                    if (!i_busyMem) begin
                        if ((USE_BURST != 0) || w_lastEmit) begin
                            r_state <= RD_WAIT;
                        end else begin
                            r_emitCnt <= r_emitCnt + 1'b1;
                        end
                    end
                end
                RD_WAIT: begin
                    if (w_rdDone) begin
                        r_state <= IDLE;
                    end
                end
                WR_BEAT: begin
                    if (!i_busyMem) begin
                        if (w_lastEmit) begin
                            r_state <= IDLE;
                        end else begin
                            r_emitCnt <= r_emitCnt + 1'b1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
            if (w_rxBeat) begin
                r_recvCnt <= r_recvCnt + 1'b1;
            end
        end
    end

    // Read line assembly and the one-cycle line-valid pulse
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_line  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= w_rdDone;
            if (w_rxBeat) begin
                for (int k = 0; k < BEATS; k++) begin
                    if (r_recvCnt == BEAT_W'(k)) begin
                        r_line[k*MEM_W +: MEM_W] <= w_rxLane;
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_psx_ddr_burst_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : tb_psx_ddr_burst_bridge
//  Description : Self-checking bench. A burst-mode and a single-beat-mode
//                bridge share client stimulus; an Avalon slave model with
//                random waitrequest/readdatavalid and a line-level reference
//                model check every request, beat and returned line.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_psx_ddr_burst_bridge;

    logic              clk = 1'b0;
    logic              rst;
    logic [1:0]        cmd;
    logic              wr;
    logic [1:0]        size;
    logic [14:0]       tAddr;
    logic [2:0]        sub;
    logic [15:0]       mask;
    logic [255:0]      dIn;
    logic              busyMem;
    logic              dvMem;
    logic [63:0]       dMem;

    logic [1:0]        busyC;
    logic [1:0]        validC;
    logic [1:0][255:0] dataC;
    logic [1:0][16:0]  addrO;
    logic [1:0][2:0]   lenO;
    logic [1:0]        rdEn;
    logic [1:0]        wrEn;
    logic [1:0][63:0]  dOut;
    logic [1:0][7:0]   beO;

    logic [1:0][255:0] expLine;
    int                nChecks = 0;
    int                nErrors = 0;
    int                dataMode = 0;
    logic [63:0]       forceBeat = 64'h0;

    always #5 clk = ~clk;

    psx_ddr_burst_bridge #(.USE_BURST(1)) u_dutBurst (
        .i_clk(clk), .i_rst(rst), .i_command(cmd[0]), .i_writeElseRead(wr),
        .i_commandSize(size), .i_targetAddr(tAddr), .i_subAddr(sub),
        .i_writeMask(mask), .i_dataClient(dIn), .o_busyClient(busyC[0]),
        .o_dataValidClient(validC[0]), .o_dataClient(dataC[0]),
        .o_targetAddr(addrO[0]), .o_burstLength(lenO[0]), .i_busyMem(busyMem),
        .o_readEnableMem(rdEn[0]), .o_writeEnableMem(wrEn[0]),
        .o_dataMem(dOut[0]), .o_byteEnableMem(beO[0]),
        .i_dataValidMem(dvMem), .i_dataMem(dMem)
    );

    psx_ddr_burst_bridge #(.USE_BURST(0)) u_dutSingle (
        .i_clk(clk), .i_rst(rst), .i_command(cmd[1]), .i_writeElseRead(wr),
        .i_commandSize(size), .i_targetAddr(tAddr), .i_subAddr(sub),
        .i_writeMask(mask), .i_dataClient(dIn), .o_busyClient(busyC[1]),
        .o_dataValidClient(validC[1]), .o_dataClient(dataC[1]),
        .o_targetAddr(addrO[1]), .o_burstLength(lenO[1]), .i_busyMem(busyMem),
        .o_readEnableMem(rdEn[1]), .o_writeEnableMem(wrEn[1]),
        .o_dataMem(dOut[1]), .o_byteEnableMem(beO[1]),
        .i_dataValidMem(dvMem), .i_dataMem(dMem)
    );

    task automatic checkVal(input string tag, input logic [255:0] act, input logic [255:0] exp);
        nChecks++;
        if (act !== exp) begin
            nErrors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [63:0] makeBeat(input int idx);
        logic [3:0] nib;
        nib = 4'(idx + 1);
        if (dataMode == 1) return {16{nib}};
        if (dataMode == 2) return forceBeat;
        return {$urandom, $urandom};
    endfunction

    // Expected write data of beat i, straight from the command semantics
    function automatic logic [63:0] expWData(input logic [1:0] sz, input logic [255:0] dat, input int i);
        if (sz == 2'd1) return dat[64*i +: 64];
        if (sz == 2'd2) return {2{dat[31:0]}};
        return dat[63:0];
    endfunction

    // Expected byteenable of beat i: byte b of the line follows halfword b/2
    function automatic logic [7:0] expBe(input logic [1:0] sz, input logic [15:0] mk, input logic [2:0] sb, input int i);
        logic [7:0] be;
        for (int b = 0; b < 8; b++) begin
            if (sz == 2'd1)      be[b] = mk[(8*i + b) / 2];
            else if (sz == 2'd2) be[b] = ((b / 4) == int'(sb[0])) ? mk[(b % 4) / 2] : 1'b0;
            else                 be[b] = 1'b1;
        end
        return be;
    endfunction

    // Issue one client command on DUT d and act as the Avalon slave until done
    task automatic runCmd(input int d, input logic w, input logic [1:0] sz, input logic [14:0] blk,
                          input logic [2:0] sb, input logic [15:0] mk, input logic [255:0] dat,
                          input int busyMode);
        logic [63:0] pend[$];
        logic [63:0] rx[$];
        logic [16:0] expAddr;
        int          n, start, reqs, wbeats, cyc, expReqs;
        bit          burst, done;
        n       = (sz == 2'd1) ? 4 : 1;
        start   = (sz == 2'd1) ? 0 : int'(sb) / 2;
        burst   = (d == 0);
        expReqs = (!w && burst) ? 1 : n;
        reqs = 0; wbeats = 0; cyc = 0; done = 0;
        @(negedge clk);
        checkVal("idle_before_cmd", 256'(busyC[d]), 256'(0));
        cmd[d] = 1'b1; wr = w; size = sz; tAddr = blk; sub = sb; mask = mk; dIn = dat;
        busyMem = 1'b0; dvMem = 1'b0;
        @(negedge clk);
        cmd[d] = 1'b0;
        checkVal("first_req", 256'(w ? wrEn[d] : rdEn[d]), 256'(1));
        checkVal("busy_after_accept", 256'(busyC[d]), 256'(1));
        while (!done && cyc < 300) begin
            cyc++;
            busyMem = (busyMode == 1) ? (cyc <= 3) : ($urandom_range(0, 2) == 0);
            dvMem = 1'b0;
            dMem  = {$urandom, $urandom};
            if (pend.size() > 0 && $urandom_range(0, 1) == 1) begin
                dvMem = 1'b1;
                dMem  = pend.pop_front();
                rx.push_back(dMem);
            end
            if (rdEn[d] && !busyMem) begin
                expAddr = {blk, 2'b00} + 17'(start + (burst ? 0 : reqs));
                checkVal("rd_addr", 256'(addrO[d]), 256'(expAddr));
                checkVal("rd_len", 256'(lenO[d]), 256'(burst ? n : 1));
                for (int k = 0; k < (burst ? n : 1); k++)
                    pend.push_back(makeBeat(rx.size() + pend.size()));
                reqs++;
            end
            if (wrEn[d] && !busyMem) begin
                expAddr = {blk, 2'b00} + 17'(start + (burst ? 0 : wbeats));
                checkVal("wr_addr", 256'(addrO[d]), 256'(expAddr));
                checkVal("wr_len", 256'(lenO[d]), 256'(burst ? n : 1));
                checkVal("wr_data", 256'(dOut[d]), 256'(expWData(sz, dat, wbeats)));
                checkVal("wr_be", 256'(beO[d]), 256'(expBe(sz, mk, sb, wbeats)));
                wbeats++;
            end
            @(negedge clk);
            if (w && wbeats == n) begin
                checkVal("wr_done_busy", 256'(busyC[d]), 256'(0));
                checkVal("wr_done_en", 256'(wrEn[d]), 256'(0));
                done = 1;
            end else if (!w && rx.size() == n) begin
                if (sz == 2'd1) begin
                    for (int i = 0; i < 4; i++) expLine[d][64*i +: 64] = rx[i];
                end else if (sz == 2'd2) begin
                    expLine[d][63:0] = rx[0] >> (sb[0] ? 32 : 0);
                end else begin
                    expLine[d][63:0] = rx[0];
                end
                checkVal("rd_valid_pulse", 256'(validC[d]), 256'(1));
                checkVal("rd_done_busy", 256'(busyC[d]), 256'(0));
                checkVal("rd_line", dataC[d], expLine[d]);
                checkVal("rd_req_count", 256'(reqs), 256'(expReqs));
                done = 1;
            end else if (!w && validC[d]) begin
                checkVal("early_valid", 256'(validC[d]), 256'(0));
            end
        end
        checkVal("cmd_completed", 256'(done), 256'(1));
        dvMem = 1'b0; busyMem = 1'b0;
        if (!w) begin
            @(negedge clk);
            checkVal("valid_one_cycle", 256'(validC[d]), 256'(0));
            checkVal("line_held", dataC[d], expLine[d]);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; cmd = 2'b00; wr = 1'b0; size = 2'd0; tAddr = '0; sub = '0;
        mask = '0; dIn = '0; busyMem = 1'b0; dvMem = 1'b0; dMem = '0;
        expLine = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int d = 0; d < 2; d++) begin
            checkVal("rst_busy", 256'(busyC[d]), 256'(0));
            checkVal("rst_rd_en", 256'(rdEn[d]), 256'(0));
            checkVal("rst_wr_en", 256'(wrEn[d]), 256'(0));
            checkVal("rst_valid", 256'(validC[d]), 256'(0));
            checkVal("rst_line", dataC[d], 256'(0));
        end

        // Full-line burst read with waitrequest high for three cycles
        dataMode = 1;
        runCmd(0, 1'b0, 2'd1, 15'h1234, 3'd0, 16'h0, 256'h0, 1);
        checkVal("burst_line_pattern", dataC[0],
                 256'h4444444444444444_3333333333333333_2222222222222222_1111111111111111);
        // Full-line single-beat read with out-of-phase readdatavalid
        runCmd(1, 1'b0, 2'd1, 15'h0abc, 3'd0, 16'h0, 256'h0, 0);
        dataMode = 0;

        // Full-line writes with alternating halfword mask
        runCmd(0, 1'b1, 2'd1, 15'h0777, 3'd0, 16'hF0F0, {8{$urandom}}, 0);
        runCmd(1, 1'b1, 2'd1, 15'h0778, 3'd0, 16'hF0F0, {8{$urandom}}, 0);

        // 4-byte write to word 3, and 4-byte read of word 5
        runCmd(0, 1'b1, 2'd2, 15'h0042, 3'd3, 16'h0003, {224'h0, 32'hDEADBEEF}, 0);
        dataMode = 2; forceBeat = 64'hCAFEBABE_12345678;
        runCmd(0, 1'b0, 2'd2, 15'h0043, 3'd5, 16'h0, 256'h0, 0);
        checkVal("rd4_low_lane", 256'(dataC[0][63:0]), 256'(64'h00000000_CAFEBABE));
        dataMode = 0;

        // Reset in the middle of a full-line burst write after two beats
        @(negedge clk);
        cmd[0] = 1'b1; wr = 1'b1; size = 2'd1; tAddr = 15'h0100; mask = 16'hFFFF;
        dIn = {8{$urandom}}; busyMem = 1'b0;
        @(negedge clk);
        cmd[0] = 1'b0;
        checkVal("rst_seq_beat0", 256'(wrEn[0]), 256'(1));
        @(negedge clk);
        checkVal("rst_seq_beat1", 256'(wrEn[0]), 256'(1));
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkVal("rst_mid_wr_en", 256'(wrEn[0]), 256'(0));
        checkVal("rst_mid_busy", 256'(busyC[0]), 256'(0));
        checkVal("rst_mid_line", dataC[0], 256'(0));
        expLine = '0;
        runCmd(0, 1'b0, 2'd0, 15'h0200, 3'd2, 16'h0, 256'h0, 0);

        // Randomised mix of commands on both bridges
        for (int t = 0; t < 40; t++) begin
            runCmd($urandom_range(0, 1), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                   15'($urandom), 3'($urandom), 16'($urandom), {8{$urandom}}, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule
`default_nettype wire
